// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte sequencer slice.
package spi_pkg;

  localparam int BYTE_COUNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE
  } seq_state_t;

endpackage

// File: rtl/spi_byte_sequencer_if.sv
// Host-side byte streams: TX bytes into the sequencer, RX bytes out of its FIFO.
interface spi_byte_sequencer_if #(
  parameter int DATA_LENGTH = 8
);

  logic [DATA_LENGTH-1:0] tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic [DATA_LENGTH-1:0] rx_data;
  logic                   rx_valid;
  logic                   rx_ready;

  // Host side: produces TX bytes, consumes RX bytes.
  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  // Sequencer side.
  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_rx_fifo.sv
// First-word fall-through RX FIFO; the sequencer guarantees it is never pushed when full.
module spi_rx_fifo #(
  parameter int DATA_LENGTH = 8,
  parameter int RX_DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_LENGTH-1:0]     push_data,
  input  logic                       pop,
  output logic [DATA_LENGTH-1:0]     head_data,
  output logic                       not_empty,
  output logic [$clog2(RX_DEPTH):0]  level
);

  localparam int PTR_W = $clog2(RX_DEPTH);

  logic [DATA_LENGTH-1:0] mem [RX_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic                   do_pop;

  assign not_empty = (level != '0);
  assign do_pop    = pop && not_empty;
  assign head_data = mem[rd_ptr];

  // Storage write.
  // NOTE: the data array is deliberately not reset; pointers and level define validity,
  // and leaving it unreset lets it map onto plain RAM/regfile cells.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap because RX_DEPTH is a power of 2.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/spi_byte_sequencer.sv
// Feeds host bytes to spi_master one transfer at a time, collects received bytes
// into an RX FIFO, counts completed transfers and flags stuck transfers.
module spi_byte_sequencer
  import spi_pkg::*;
#(
  parameter int DATA_LENGTH    = 8,
  parameter int RX_DEPTH       = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_byte_sequencer_if.slave        host,
  output logic                       spi_start,
  output logic [DATA_LENGTH-1:0]     spi_data_in,
  input  logic [DATA_LENGTH-1:0]     spi_data_out,
  input  logic                       spi_busy,
  input  logic                       spi_done,
  output logic [$clog2(RX_DEPTH):0]  rx_level,
  output logic [BYTE_COUNT_W-1:0]    byte_count,
  output logic                       timeout_err,
  input  logic                       err_clr
);

  localparam int LVL_W = $clog2(RX_DEPTH) + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LVL_W-1:0] LVL_LIMIT = LVL_W'(RX_DEPTH);

  seq_state_t             state;
  logic [WD_W-1:0]        wd_cnt;
  logic                   rx_push;
  logic                   fifo_not_empty;
  logic [DATA_LENGTH-1:0] fifo_head;

  // Only one byte is ever in flight, so requiring a free slot at accept time
  // reserves that slot: the eventual push can never meet a full FIFO.
  assign host.tx_ready = (state == IDLE) && !rst && (rx_level < LVL_LIMIT) &&
                         !timeout_err && !spi_busy && !spi_done;

  // spi_data_out is only trusted on the done pulse of a transfer we launched.
  assign rx_push = (state == WAIT_DONE) && spi_done;

  assign host.rx_data  = fifo_head;
  assign host.rx_valid = fifo_not_empty;

  spi_rx_fifo #(
    .DATA_LENGTH (DATA_LENGTH),
    .RX_DEPTH    (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (spi_data_out),
    .pop       (host.rx_ready),
    .head_data (fifo_head),
    .not_empty (fifo_not_empty),
    .level     (rx_level)
  );

  // Transfer FSM with registered start pulse, watchdog, byte counter and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      spi_start   <= 1'b0;
      spi_data_in <= '0;
      wd_cnt      <= '0;
      byte_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      spi_start <= 1'b0;
      // Clear first so a timeout set later in this block wins the same cycle.
      if (err_clr) begin
        timeout_err <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (host.tx_valid && host.tx_ready) begin
            spi_data_in <= host.tx_data;
            spi_start   <= 1'b1;
            state       <= LAUNCH;
          end
        end
        LAUNCH: begin
          wd_cnt <= '0;
          state  <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (spi_done) begin
            byte_count <= byte_count + 1'b1;
            state      <= IDLE;
          end else if (wd_cnt == WD_LIMIT) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Directed bench for spi_byte_sequencer with a behavioural spi_master/slave model
// and a queue-based RX scoreboard.
module tb_spi_byte_sequencer;
  import spi_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int TO    = 64;
  localparam int LAT   = 20;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_byte_sequencer_if #(.DATA_LENGTH(DW)) bus ();

  logic          spi_start;
  logic [DW-1:0] spi_data_in;
  logic [DW-1:0] spi_data_out = '0;
  logic          spi_busy = 1'b0;
  logic          spi_done = 1'b0;
  logic [LW-1:0] rx_level;
  logic [15:0]   byte_count;
  logic          timeout_err;
  logic          err_clr = 1'b0;

  spi_byte_sequencer #(
    .DATA_LENGTH    (DW),
    .RX_DEPTH       (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .host         (bus.slave),
    .spi_start    (spi_start),
    .spi_data_in  (spi_data_in),
    .spi_data_out (spi_data_out),
    .spi_busy     (spi_busy),
    .spi_done     (spi_done),
    .rx_level     (rx_level),
    .byte_count   (byte_count),
    .timeout_err  (timeout_err),
    .err_clr      (err_clr)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  // spi_master + slave model: fixed 0x3C reply or echo of the byte sent.
  bit            echo_mode = 1'b0;
  bit            hang      = 1'b0;
  logic [DW-1:0] cap       = '0;
  int            lat_cnt   = 0;

  always @(posedge clk) begin
    spi_done <= 1'b0;
    if (spi_start) begin
      cap      <= spi_data_in;
      spi_busy <= 1'b1;
      lat_cnt  <= LAT;
    end else if (spi_busy && !hang) begin
      if (lat_cnt == 0) begin
        spi_busy     <= 1'b0;
        spi_done     <= 1'b1;
        spi_data_out <= echo_mode ? cap : 8'h3C;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  // Monitor: start-pulse bookkeeping and RX scoreboard, sampled on the falling edge.
  logic [DW-1:0] exp_q[$];
  int ncyc      = 0;
  int starts    = 0;
  int start_cyc = 0;
  int last_done = -100;

  always @(negedge clk) begin
    ncyc++;
    if (spi_done) last_done = ncyc;
    if (spi_start) begin
      starts++;
      start_cyc = ncyc;
      check("start_gap_ge2", 32'(ncyc - last_done >= 2), 1);
    end
    if (!rst && bus.rx_valid && bus.rx_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_extra: got=0x%0h want=none", bus.rx_data);
      end else begin
        check("rx_data", bus.rx_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // NOTE: bench drives DUT inputs with blocking assignments, #1 after the active edge.
  task automatic send_byte(input logic [DW-1:0] b, input bit expect_rx,
                           input logic [DW-1:0] exp, input bit hold);
    bit ok;
    ok = 1'b0;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (bus.tx_ready) ok = 1'b1;
      tick();
    end
    if (ok && expect_rx) exp_q.push_back(exp);
    if (!hold) bus.tx_valid = 1'b0;
    check("tx_accept", 32'(ok), 1);
  endtask

  // Polls after each edge; returns with spi_done high in the current cycle.
  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (spi_done) ok = 1'b1;
    end
    check("spi_done_seen", 32'(ok), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1);
  end

  initial begin
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;

    // Reset values.
    rst = 1'b1;
    repeat (3) tick();
    check("rst_tx_ready", 32'(bus.tx_ready), 0);
    check("rst_rx_valid", 32'(bus.rx_valid), 0);
    check("rst_spi_start", 32'(spi_start), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    check("rst_spi_data_in", spi_data_in, 0);
    check("rst_rx_level", rx_level, 0);
    check("rst_byte_count", byte_count, 0);
    rst = 1'b0;
    tick();
    check("idle_tx_ready", 32'(bus.tx_ready), 1);

    // Single byte, fixed 0x3C reply.
    send_byte(8'hA5, 1'b1, 8'h3C, 1'b0);
    wait_done();
    check("t1_data_in_hold", spi_data_in, 8'hA5);
    check("t1_cap", cap, 8'hA5);
    check("t1_rx_valid_at_done", 32'(bus.rx_valid), 0);
    tick();
    check("t1_rx_valid_after", 32'(bus.rx_valid), 1);
    check("t1_rx_head", bus.rx_data, 8'h3C);
    check("t1_byte_count", byte_count, 1);
    check("t1_starts", starts, 1);
    bus.rx_ready = 1'b1;
    tick();

    // Back-to-back with echo, rx_ready held high.
    echo_mode = 1'b1;
    send_byte(8'h01, 1'b1, 8'h01, 1'b1);
    send_byte(8'h02, 1'b1, 8'h02, 1'b1);
    send_byte(8'h03, 1'b1, 8'h03, 1'b1);
    send_byte(8'h04, 1'b1, 8'h04, 1'b0);
    wait_done();
    repeat (3) tick();
    check("t2_starts", starts, 5);
    check("t2_byte_count", byte_count, 5);
    check("t2_rx_level", rx_level, 0);

    // Back-pressure: rx_ready low, six bytes offered.
    bus.rx_ready = 1'b0;
    send_byte(8'h10, 1'b1, 8'h10, 1'b1);
    send_byte(8'h11, 1'b1, 8'h11, 1'b1);
    send_byte(8'h12, 1'b1, 8'h12, 1'b1);
    send_byte(8'h13, 1'b1, 8'h13, 1'b1);
    bus.tx_data = 8'h14;
    repeat (60) tick();
    check("t3_full_tx_ready", 32'(bus.tx_ready), 0);
    check("t3_full_level", rx_level, 4);
    check("t3_full_starts", starts, 9);
    // Pop while full: the offered byte must not be accepted in the same cycle.
    bus.rx_ready = 1'b1;
    @(negedge clk);
    check("t3_pop_cycle_tx_ready", 32'(bus.tx_ready), 0);
    tick();
    bus.rx_ready = 1'b0;
    send_byte(8'h14, 1'b1, 8'h14, 1'b1);
    bus.tx_data = 8'h15;
    repeat (60) tick();
    check("t3_refill_tx_ready", 32'(bus.tx_ready), 0);
    check("t3_refill_level", rx_level, 4);
    check("t3_refill_starts", starts, 10);
    bus.tx_valid = 1'b0;
    // Drop to level 3, then push and pop in the same cycle.
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    check("t3_level3", rx_level, 3);
    send_byte(8'h15, 1'b1, 8'h15, 1'b0);
    wait_done();
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    check("t3_push_pop_level", rx_level, 3);
    check("t3_byte_count", byte_count, 11);
    bus.rx_ready = 1'b1;
    repeat (10) tick();
    check("t3_drained", rx_level, 0);

    // Timeout: slave never completes until released.
    hang = 1'b1;
    send_byte(8'h77, 1'b0, 8'h00, 1'b0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < TO + 50 && !seen; i++) begin
        tick();
        if (timeout_err) seen = 1'b1;
      end
      check("t4_timeout_seen", 32'(seen), 1);
    end
    check("t4_timeout_latency", ncyc - start_cyc, TO);
    check("t4_level", rx_level, 0);
    check("t4_tx_ready", 32'(bus.tx_ready), 0);
    check("t4_byte_count", byte_count, 11);
    hang = 1'b0;
    wait_done();
    repeat (3) tick();
    check("t4_late_done_level", rx_level, 0);
    check("t4_late_done_count", byte_count, 11);
    check("t4_err_sticky", 32'(timeout_err), 1);
    check("t4_err_tx_ready", 32'(bus.tx_ready), 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_err_cleared", 32'(timeout_err), 0);
    check("t4_tx_ready_restored", 32'(bus.tx_ready), 1);

    // Reset mid-transfer; the stale done must be ignored.
    send_byte(8'h99, 1'b0, 8'h00, 1'b0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("t5_tx_ready", 32'(bus.tx_ready), 0);
    check("t5_rx_valid", 32'(bus.rx_valid), 0);
    check("t5_spi_start", 32'(spi_start), 0);
    check("t5_timeout_err", 32'(timeout_err), 0);
    check("t5_spi_data_in", spi_data_in, 0);
    check("t5_rx_level", rx_level, 0);
    check("t5_byte_count", byte_count, 0);
    rst = 1'b0;
    wait_done();
    repeat (3) tick();
    check("t5_stale_level", rx_level, 0);
    check("t5_stale_count", byte_count, 0);
    send_byte(8'h5A, 1'b1, 8'h5A, 1'b0);
    wait_done();
    repeat (3) tick();
    check("t5_recover_count", byte_count, 1);
    check("t5_recover_level", rx_level, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_byte_sequencer.md
Name: spi_byte_sequencer

Overview:
- Sits directly upstream of spi_master and feeds it bytes.
- Accepts a valid/ready byte stream from the host side, issues one spi_master transfer per byte, and returns each received byte through an RX FIFO on a valid/ready output.
- Also provides RX back-pressure, a completed-byte counter and a stuck-transfer watchdog.

Parameters:
- DATA_LENGTH, 8: byte width; must match the spi_master instance.
- RX_DEPTH, 4: RX FIFO entries; power of 2, at least 2.
- TIMEOUT_CYCLES, 1024: clk cycles allowed from start to done. Must exceed 2*CLK_DIV*(DATA_LENGTH+1)+8.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  DATA_LENGTH  byte to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  sequencer accepts tx_data this cycle.
- rx_data  out  DATA_LENGTH  RX FIFO head.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  consumer pops the head when rx_valid is 1.
- spi_start  out  1  one-cycle start pulse to spi_master.
- spi_data_in  out  DATA_LENGTH  byte to spi_master; held stable from accept until done.
- spi_data_out  in  DATA_LENGTH  received byte from spi_master; valid only while spi_done is 1.
- spi_busy  in  1  spi_master busy.
- spi_done  in  1  spi_master one-cycle completion pulse.
- rx_level  out  $clog2(RX_DEPTH)+1  FIFO occupancy.
- byte_count  out  16  completed transfers; wraps 0xFFFF to 0.
- timeout_err  out  1  sticky watchdog error.
- err_clr  in  1  clears timeout_err.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state IDLE, FIFO emptied.
  - tx_ready, rx_valid, spi_start, timeout_err all 0.
  - spi_data_in, rx_level, byte_count all 0.
  - Watchdog counter 0.
  - Reset mid-transfer abandons the byte; a later spi_done is ignored.
- States: IDLE, LAUNCH, WAIT_DONE.
- IDLE:
  - tx_ready = (rx_level < RX_DEPTH) && !timeout_err && !spi_busy && !spi_done. This is combinational from registered state and inputs.
  - On tx_valid && tx_ready: register spi_data_in <= tx_data, go to LAUNCH.
- LAUNCH:
  - spi_start = 1 for exactly this cycle.
  - Watchdog loads 0.
  - Go to WAIT_DONE.
- WAIT_DONE:
  - Watchdog increments each cycle.
  - On spi_done: push spi_data_out into the FIFO this same cycle (no other capture point), byte_count += 1, go to IDLE.
  - If the watchdog reaches TIMEOUT_CYCLES-1 without spi_done: timeout_err <= 1, go to IDLE, push nothing.
  - If spi_done and the watchdog limit occur in the same cycle, spi_done wins.
- Throughput: the next tx accept is possible the cycle after spi_done, so spi_start reaches spi_master while it is in IDLE.
- RX slot reservation:
  - A byte is only accepted when a FIFO slot is free.
  - A pop cannot un-free that slot, so a push never meets a full FIFO; overflow is impossible by construction.
- RX FIFO:
  - First-word fall-through: a push at edge t gives rx_valid=1 after t.
  - Pop when rx_valid && rx_ready. Pop on empty is ignored.
  - Simultaneous push and pop leaves rx_level unchanged, with data order preserved.
  - Pointers wrap modulo RX_DEPTH.
- timeout_err:
  - Sticky; cleared by err_clr.
  - If set and err_clr occur in the same cycle, set wins.
  - While set, tx_ready=0; the FIFO still drains.
- spi_done outside WAIT_DONE (late after timeout, or after reset) is ignored: no push, no count.

Decomposition:
- Package spi_pkg holds the seq_state_t enum (IDLE, LAUNCH, WAIT_DONE) and the BYTE_COUNT_W=16 constant.
- One natural sub-module: spi_rx_fifo (parameters DATA_LENGTH, RX_DEPTH; push, pop, data, level, same reset).
- The sequencer FSM and watchdog stay in spi_byte_sequencer.

Test Plan:
- Single byte, spi_master with MISO looped from a slave model returning 0x3C: send tx_data=0xA5. Expect exactly one spi_start pulse, spi_data_in=0xA5 until done, rx_data=0x3C with rx_valid the cycle after spi_done, byte_count=1.
- Back-to-back, tx_valid held high with 0x01,0x02,0x03,0x04 and rx_ready=1: expect 4 start pulses, each at least 2 cycles after the prior spi_done. rx_data order is 0x01..0x04 with an echoing slave; byte_count=4.
- Back-pressure, RX_DEPTH=4, rx_ready=0, 6 bytes offered: expect 4 transfers, then tx_ready=0 with rx_level=4. Pop one byte, then exactly one more transfer; no overflow.
- Timeout, spi_done tied 0: expect timeout_err=1 at cycle TIMEOUT_CYCLES after LAUNCH, FIFO unchanged, tx_ready=0. A late spi_done pulse changes nothing. err_clr then restores tx_ready=1.
- Reset mid-transfer, rst=1 during WAIT_DONE: expect all outputs at reset values the next cycle. The subsequent stale spi_done is ignored and rx_level stays 0.
- FIFO boundary, rx_level=4 with a pop in the same cycle as tx accept: accept only occurs if rx_level<4 beforehand. The simultaneous push and pop at rx_level=3 keeps rx_level=3.
